// File: rtl/sine_sample_gen.sv
// Sine sample generator: 16-point symmetric LUT, one registered sample every hold+1 clocks.
// No backpressure; en low parks the generator in IDLE, phase_clr restarts the phase and divider.
module sine_sample_gen #(
  parameter int SAMPLE_W = 8,
  parameter int HOLD_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       phase_clr,
  input  logic [1:0]                 phase_step,
  input  logic [HOLD_W-1:0]          hold_cycles,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid,
  output logic [3:0]                 phase,
  output logic                       wrap
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Quarter-wave amplitudes: round(sin(k*22.5deg) * (2^(W-1)-1)), sines held as Q0.30.
  localparam longint AMP  = (64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1;
  localparam longint HALF = 64'sd1 <<< 29;
  localparam longint Q1_L = (AMP * 64'sd410903207 + HALF) >>> 30;
  localparam longint Q2_L = (AMP * 64'sd759250125 + HALF) >>> 30;
  localparam longint Q3_L = (AMP * 64'sd992008094 + HALF) >>> 30;
  localparam logic [SAMPLE_W-1:0] Q1 = Q1_L[SAMPLE_W-1:0];
  localparam logic [SAMPLE_W-1:0] Q2 = Q2_L[SAMPLE_W-1:0];
  localparam logic [SAMPLE_W-1:0] Q3 = Q3_L[SAMPLE_W-1:0];
  localparam logic [SAMPLE_W-1:0] Q4 = AMP[SAMPLE_W-1:0];

  state_t                     state, state_nxt;
  logic [HOLD_W-1:0]          div;
  logic [HOLD_W-1:0]          hold_lat;
  logic                       emit;
  logic [4:0]                 phase_sum;
  logic [2:0]                 qidx;
  logic [SAMPLE_W-1:0]        mag;
  logic signed [SAMPLE_W-1:0] lut_val;

  assign phase_sum = {1'b0, phase} + {3'b000, phase_step};

  // Odd quadrants walk the quarter table backwards; the upper half is negated.
  always_comb begin
    qidx = phase[2] ? (3'd4 - {1'b0, phase[1:0]}) : {1'b0, phase[1:0]};
    case (qidx)
      3'd0:    mag = '0;
      3'd1:    mag = Q1;
      3'd2:    mag = Q2;
      3'd3:    mag = Q3;
      default: mag = Q4;
    endcase
    lut_val = phase[3] ? -$signed(mag) : $signed(mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (!en)                                  state_nxt = IDLE;
        else if (!phase_clr && div == hold_lat)   emit = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div          <= '0;
      hold_lat     <= '0;
      phase        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= emit;
      wrap         <= emit & phase_sum[4];
      if (state == IDLE && en) hold_lat <= hold_cycles;
      if (phase_clr) begin
        phase <= '0;
        div   <= '0;
      end else if (state == IDLE) begin
        if (en) div <= '0;
      end else if (en) begin
        if (emit) begin
          div    <= '0;
          sample <= lut_val;
          phase  <= phase_sum[3:0];
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_sample_gen.sv
// Directed bench for sine_sample_gen: table of sample streams plus hand sequences for corner cases.
module tb_sine_sample_gen;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              phase_clr = 1'b0;
  logic [1:0]        phase_step = 2'd0;
  logic [15:0]       hold_cycles = 16'd0;
  logic signed [7:0] sample;
  logic              sample_valid;
  logic [3:0]        phase;
  logic              wrap;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sine_sample_gen #(.SAMPLE_W(8), .HOLD_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .phase_clr    (phase_clr),
    .phase_step   (phase_step),
    .hold_cycles  (hold_cycles),
    .sample       (sample),
    .sample_valid (sample_valid),
    .phase        (phase),
    .wrap         (wrap)
  );

  // start: reset + enable before this record; gap: edges since previous valid (or since en raised)
  typedef struct {
    bit start;
    int hold;
    int step;
    int gap;
    int smp;
    int wrp;
    int ph;
  } vec_t;

  vec_t vecs[29] = '{
    '{1, 3, 1, 5,    0, 0,  1}, '{0, 3, 1, 4,   49, 0,  2}, '{0, 3, 1, 4,   90, 0,  3},
    '{0, 3, 1, 4,  117, 0,  4}, '{0, 3, 1, 4,  127, 0,  5}, '{0, 3, 1, 4,  117, 0,  6},
    '{0, 3, 1, 4,   90, 0,  7}, '{0, 3, 1, 4,   49, 0,  8}, '{0, 3, 1, 4,    0, 0,  9},
    '{0, 3, 1, 4,  -49, 0, 10}, '{0, 3, 1, 4,  -90, 0, 11}, '{0, 3, 1, 4, -117, 0, 12},
    '{0, 3, 1, 4, -127, 0, 13}, '{0, 3, 1, 4, -117, 0, 14}, '{0, 3, 1, 4,  -90, 0, 15},
    '{0, 3, 1, 4,  -49, 1,  0}, '{0, 3, 1, 4,    0, 0,  1},
    '{1, 0, 2, 2,    0, 0,  2}, '{0, 0, 2, 1,   90, 0,  4}, '{0, 0, 2, 1,  127, 0,  6},
    '{0, 0, 2, 1,   90, 0,  8}, '{0, 0, 2, 1,    0, 0, 10}, '{0, 0, 2, 1,  -90, 0, 12},
    '{0, 0, 2, 1, -127, 0, 14}, '{0, 0, 2, 1,  -90, 1,  0}, '{0, 0, 2, 1,    0, 0,  2},
    '{1, 1, 0, 3,    0, 0,  0}, '{0, 1, 0, 2,    0, 0,  0}, '{0, 1, 0, 2,    0, 0,  0}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_valid && n < 40);
    if (!sample_valid) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: no sample_valid within %0d clocks, expected one", n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    bit saw;
    bit found;

    for (int i = 0; i < 29; i++) begin
      if (vecs[i].start) begin
        en          = 1'b0;
        hold_cycles = 16'(vecs[i].hold);
        phase_step  = 2'(vecs[i].step);
        do_reset();
        check("rst_sample", int'(sample), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_wrap", int'(wrap), 0);
        en = 1'b1;
      end
      wait_valid(n);
      check($sformatf("v%0d_gap", i), n, vecs[i].gap);
      check($sformatf("v%0d_sample", i), int'(sample), vecs[i].smp);
      check($sformatf("v%0d_wrap", i), int'(wrap), vecs[i].wrp);
      check($sformatf("v%0d_phase", i), int'(phase), vecs[i].ph);
    end

    // en dropped for 20 clocks after the fifth sample, hold=9
    en = 1'b0; hold_cycles = 16'd9; phase_step = 2'd1;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 5; k++) wait_valid(n);
    check("pause_pre_sample", int'(sample), 127);
    en = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (sample_valid || wrap) saw = 1'b1;
    end
    check("pause_no_valid", int'(saw), 0);
    check("pause_sample", int'(sample), 127);
    check("pause_phase", int'(phase), 5);
    en = 1'b1;
    wait_valid(n);
    check("resume_gap", n, 11);
    check("resume_sample", int'(sample), 117);

    // phase_clr on the terminal-count edge with phase=7
    wait_valid(n);
    check("pre_clr_phase", int'(phase), 7);
    repeat (9) tick();
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    check("clr_valid", int'(sample_valid), 0);
    check("clr_phase", int'(phase), 0);
    check("clr_sample", int'(sample), 90);
    wait_valid(n);
    check("post_clr_gap", n, 10);
    check("post_clr_sample", int'(sample), 0);

    // async reset between edges while sample=-117
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      wait_valid(n);
      if (sample == -8'sd117) found = 1'b1;
    end
    check("found_m117", int'(sample), -117);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_sample", int'(sample), 0);
    check("arst_phase", int'(phase), 0);
    check("arst_valid", int'(sample_valid), 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (15) begin
      tick();
      if (sample_valid) saw = 1'b1;
    end
    check("arst_idle", int'(saw), 0);
    en = 1'b1;
    wait_valid(n);
    check("arst_restart_gap", n, 11);
    check("arst_restart_sample", int'(sample), 0);

    // hold change mid-RUN only takes effect after en is cycled
    en = 1'b0; hold_cycles = 16'd3; phase_step = 2'd1;
    do_reset();
    en = 1'b1;
    wait_valid(n);
    check("hold_first_gap", n, 5);
    hold_cycles = 16'd7;
    wait_valid(n);
    check("hold_old_gap1", n, 4);
    wait_valid(n);
    check("hold_old_gap2", n, 4);
    en = 1'b0;
    tick();
    en = 1'b1;
    wait_valid(n);
    check("hold_new_first", n, 9);
    wait_valid(n);
    check("hold_new_gap", n, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sine_sample_gen.md
SINE_SAMPLE_GEN -- requirements
Module: sine_sample_gen

Interface
REQ-001 Parameter: SAMPLE_W, default 8, width of signed output sample (Q1.7 when 8).
REQ-002 Parameter: HOLD_W, default 16, width of sample-period control.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: en  input  1  run enable; high = generate samples.
REQ-006 Port: phase_clr  input  1  synchronous phase/divider clear.
REQ-007 Port: phase_step  input  2  phase increment per sample (0..3).
REQ-008 Port: hold_cycles  input  HOLD_W  sample period minus one, in clocks.
REQ-009 Port: sample  output  SAMPLE_W  signed sine sample, registered; feeds the downstream 8-stage delay line / tap summer.
REQ-010 Port: sample_valid  output  1  one-cycle pulse when sample updates.
REQ-011 Port: phase  output  4  index of the next sample to be emitted.
REQ-012 Port: wrap  output  1  one-cycle pulse, coincident with sample_valid, when phase passes 15 -> 0.

Function
REQ-013 The block SHALL be a 2-state FSM: IDLE, RUN.
REQ-014 IDLE -> RUN SHALL occur on the edge where en=1; on that edge the divider SHALL load 0 and hold_cycles SHALL be latched internally.
REQ-015 RUN -> IDLE SHALL occur on any edge where en=0; phase and sample SHALL hold their values and sample_valid SHALL be 0.
REQ-016 Changes to hold_cycles during RUN SHALL be ignored until the next IDLE -> RUN transition.
REQ-017 In RUN the divider SHALL increment each cycle and, on the edge where divider == latched hold, SHALL return to 0 and emit a sample; the sample period SHALL be exactly hold+1 clocks.
REQ-018 On emit: sample <= LUT(phase), sample_valid <= 1, phase <= (phase + phase_step) mod 16, wrap <= 1 iff phase + phase_step > 15.
REQ-019 First sample_valid after the IDLE -> RUN edge SHALL occur hold+1 edges later (hold=0: next edge).
REQ-020 LUT: 16 points per cycle, 22.5 deg spacing, quarter-wave table {0, 49, 90, 117, 127} indexed by offset = phase[1:0].
REQ-021 Quadrant phase[3:2]: 0 -> Q[off]; 1 -> Q[4-off]; 2 -> -Q[off]; 3 -> -Q[4-off].
REQ-022 Resulting sequence for phase 0..15: 0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49.
REQ-023 Output SHALL be symmetric: full scale +127/-127; -128 SHALL never be produced.
REQ-024 For SAMPLE_W other than 8, table values SHALL be round(sin * (2^(SAMPLE_W-1) - 1)).
REQ-025 phase_step = 0 SHALL emit samples at the normal rate with phase held (constant output, wrap never asserted).
REQ-026 phase_clr = 1 SHALL set phase to 0 and divider to 0 on that edge, suppress any emit on that edge, and leave state and sample unchanged; phase_clr SHALL take priority over a coincident terminal count.
REQ-027 en = 0 SHALL take priority over a coincident terminal count: no emit.
REQ-028 sample_valid and wrap SHALL never be high for two consecutive cycles when hold >= 1.

Reset
REQ-029 rst_n = 0 SHALL asynchronously force: state IDLE, divider 0, phase 0, sample 0, sample_valid 0, wrap 0.
REQ-030 Reset asserted mid-RUN SHALL abort the period; after release the block SHALL remain IDLE until en is sampled high.

Verification
REQ-031 hold=3, step=1, en held high from reset release: sample_valid every 4 clocks; samples 0, 49, 90, 117, 127, 117, ... ; wrap with the 16th sample (-49); 17th sample 0.
REQ-032 hold=0, step=2: valid every clock (continuous), samples 0, 90, 127, 90, 0, -90, -127, -90, repeat; wrap every 8th sample.
REQ-033 hold=9, step=1, drop en for 20 clocks after 5th sample (127), re-raise: sample holds 127, phase=5, next sample 117 arrives 10 clocks after re-enable edge.
REQ-034 Assert phase_clr on a terminal-count edge with phase=7: no valid that edge; phase=0; next sample 0 one full period later.
REQ-035 Assert rst_n=0 asynchronously between edges mid-RUN with sample=-117: sample, phase, sample_valid go to 0 immediately, before the next clock edge.
REQ-036 Change hold_cycles from 3 to 7 mid-RUN: period stays 4 clocks until en is cycled low/high, then becomes 8.
